// File: rtl/rns_mod21_mac.sv
// Modular multiply-accumulate for one RNS channel: sum(a*b) mod MOD over a frame.
// Shift-add multiply (one bit of b per cycle), one accumulate cycle, then hand-off.
module rns_mod21_mac #(
   parameter int MOD   = 21,
   parameter int W     = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_res,
   output logic [CNT_W-1:0] out_count,
   output logic             out_err
);
   // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
   // in_ready is high only in IDLE, out_valid only in DONE, and out_* hold while stalled.
   localparam int               BIT_W   = (W > 1) ? $clog2(W) : 1;
   localparam logic [W:0]       MOD_E   = (W + 1)'(MOD);
   localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(W - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_ACC, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d, p_q, p_d, acc_q, acc_d;
   logic [BIT_W-1:0] bit_q, bit_d;
   logic             last_q, last_d, err_q, err_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [W-1:0]     dbl;

   // Inputs are below 2*MOD, so one conditional subtract lands in 0..MOD-1.
   function automatic logic [W-1:0] red1(input logic [W:0] x);
      logic [W:0] r;
      r = (x >= MOD_E) ? x - MOD_E : x;
      return r[W-1:0];
   endfunction

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      p_d       = p_q;
      acc_d     = acc_q;
      bit_d     = bit_q;
      last_d    = last_q;
      err_d     = err_q;
      count_d   = count_q;
      dbl       = red1({p_q, 1'b0});
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_res   = '0;
      out_count = '0;
      out_err   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_d    = red1({1'b0, in_a});
               b_d    = red1({1'b0, in_b});
               last_d = in_last;
               if (({1'b0, in_a} >= MOD_E) || ({1'b0, in_b} >= MOD_E)) err_d = 1'b1;
               p_d     = '0;
               bit_d   = BIT_TOP;
               state_d = ST_MUL;
            end
         end
         ST_MUL: begin
            // MSB-first Horner step: p = 2p (+ a) mod MOD.
            p_d = b_q[bit_q] ? red1({1'b0, dbl} + {1'b0, a_q}) : dbl;
            if (bit_q == '0) state_d = ST_ACC;
            else             bit_d   = bit_q - BIT_W'(1);
         end
         ST_ACC: begin
            acc_d = red1({1'b0, acc_q} + {1'b0, p_q});
            if (count_q != '1) count_d = count_q + CNT_W'(1);
            state_d = last_q ? ST_DONE : ST_IDLE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            out_res   = acc_q;
            out_count = count_q;
            out_err   = err_q;
            if (out_ready) begin
               acc_d   = '0;
               count_d = '0;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         acc_q   <= '0;
         bit_q   <= '0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         acc_q   <= acc_d;
         bit_q   <= bit_d;
         last_q  <= last_d;
         err_q   <= err_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_rns_mod21_mac.sv
// Directed bench for rns_mod21_mac with a small reference model for long frames.
module tb_rns_mod21_mac;
   localparam int MOD = 21;
   localparam int W   = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, in_last;
   logic [4:0] in_a, in_b;
   logic       out_valid, out_ready, out_err;
   logic [4:0] out_res;
   logic [7:0] out_count;

   int     errors = 0;
   int     checks = 0;
   longint t_acc;

   rns_mod21_mac #(.MOD(MOD), .W(W), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_count(out_count), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Waits for in_ready at a falling edge, presents the pair, then scrambles the
   // operand pins after the accept edge so late changes must be ignored.
   task automatic send_pair(input logic [4:0] a, input logic [4:0] b, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", 32'(n < 2000), 1);
      in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid = 1'b0;
      in_a     = 5'($urandom_range(0, 31));
      in_b     = 5'($urandom_range(0, 31));
      in_last  = 1'($urandom_range(0, 1));
   endtask

   task automatic get_result(input string tag, input int res, input int cnt, input int err,
                             input int delay);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(out_valid), 1);
      chk({tag, "_res"},   32'(out_res),   32'(res));
      chk({tag, "_count"}, 32'(out_count), 32'(cnt));
      chk({tag, "_err"},   32'(out_err),   32'(err));
      repeat (delay) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_released"}, 32'(out_valid), 0);
   endtask

   initial begin
      longint t1;
      int     n;
      int     m_acc, m_cnt, m_err, ar, br, a, b, len;
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_res",   32'(out_res),   0);
      chk("rst_out_count", 32'(out_count), 0);
      chk("rst_out_err",   32'(out_err),   0);
      rst = 1'b0;

      // Single-pair frame: result valid right after edge k+W+1.
      send_pair(5, 7, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t1_latency", 32'(n), 32'(W + 1));
      chk("t1_in_ready_low", 32'(in_ready), 0);
      get_result("t1", 14, 1, 0, 0);

      // 20*20 = 400 = 1 mod 21 twice, plus 1 -> 3; back-to-back accept spacing W+2.
      send_pair(20, 20, 1'b0);
      t1 = t_acc;
      send_pair(20, 20, 1'b0);
      chk("t2_spacing", 32'((t_acc - t1) / 10), 32'(W + 2));
      send_pair(1, 1, 1'b1);
      get_result("t2", 3, 3, 0, 0);

      // Out-of-range operand: 25 -> 4, 4*3 = 12, sticky error cleared per frame.
      send_pair(25, 3, 1'b1);
      get_result("t3a", 12, 1, 1, 0);
      send_pair(2, 2, 1'b1);
      get_result("t3b", 4, 1, 0, 0);

      // Backpressure: result held for 10 cycles with input blocked.
      send_pair(4, 4, 1'b1);
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         chk("t4_hold_valid", 32'(out_valid), 1);
         chk("t4_hold_res",   32'(out_res),   16);
         chk("t4_hold_count", 32'(out_count), 1);
         chk("t4_hold_ready", 32'(in_ready),  0);
         @(negedge clk);
      end
      get_result("t4", 16, 1, 0, 0);

      // Reset on the 3rd MUL edge discards the frame.
      send_pair(9, 9, 1'b1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("t5_in_ready", 32'(in_ready), 1);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      chk("t5_no_valid", 32'(n), 0);
      send_pair(3, 5, 1'b1);
      get_result("t5", 15, 1, 0, 0);

      // Long frames against a reference model; the first one saturates the count.
      for (int f = 0; f < 5; f++) begin
         len = (f == 0) ? 300 : $urandom_range(1, 40);
         m_acc = 0; m_cnt = 0; m_err = 0;
         for (int i = 0; i < len; i++) begin
            a  = $urandom_range(0, 31);
            b  = $urandom_range(0, 31);
            ar = (a >= MOD) ? a - MOD : a;
            br = (b >= MOD) ? b - MOD : b;
            m_acc = (m_acc + ar * br) % MOD;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (a >= MOD || b >= MOD) m_err = 1;
            send_pair(5'(a), 5'(b), 1'(i == len - 1));
         end
         get_result("t6", m_acc, m_cnt, m_err, $urandom_range(0, 5));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
